// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared state, opcode and mux-select encodings
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_ALUWB, S_BEQ
  } state_t;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] IMM_OTHER = 2'b00;
  localparam logic [1:0] IMM_SW    = 2'b01;
  localparam logic [1:0] IMM_BEQ   = 2'b10;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/status inputs and datapath control outputs
interface multicycle_control_if;
  logic [6:0] Opcode;
  logic       ZeroFlag;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] ALUOp;
  logic       RegWrite;
  logic       InstrDone;
  logic       IllegalInstr;
  modport slave (
    input  Opcode, ZeroFlag, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUOp, RegWrite, InstrDone, IllegalInstr
  );
  modport master (
    output Opcode, ZeroFlag, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUOp, RegWrite, InstrDone, IllegalInstr
  );
endinterface

// File: rtl/multicycle_control_imm_decode.sv
// ctrl_imm_decode: opcode to immediate-format select, independent of FSM state
module ctrl_imm_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);
  always_comb imm_src = opcode == OP_SW ? IMM_SW : opcode == OP_BEQ ? IMM_BEQ : IMM_OTHER;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle lw/sw/R-type/beq datapath
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic clk,
  input logic rst_n,
  multicycle_control_if.slave bus
);
  state_t state_q, state_d;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  ctrl_imm_decode u_imm (.opcode(bus.Opcode), .imm_src(bus.ImmSrc));
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    alu_op        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
        state_d    = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_d   = bus.Opcode == OP_SW ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = bus.MemReady;
        state_d    = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALU_SUB;
        pc_write   = bus.ZeroFlag;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // in reset the outputs look like an idle FETCH whatever state is still held
    if (!rst_n) begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;
      result_src    = RES_ALURESULT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_FOUR;
      alu_op        = ALU_ADD;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  assign bus.PCWrite      = pc_write;
  assign bus.AdrSrc       = adr_src;
  assign bus.MemWrite     = mem_write;
  assign bus.IRWrite      = ir_write;
  assign bus.ResultSrc    = result_src;
  assign bus.ALUSrcA      = alu_src_a;
  assign bus.ALUSrcB      = alu_src_b;
  assign bus.ALUOp        = alu_op;
  assign bus.RegWrite     = reg_write;
  assign bus.InstrDone    = instr_done;
  assign bus.IllegalInstr = illegal_instr;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench for the multicycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [16:0] vec;
    string       name;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, BAD = 7'b1111111;
  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUOp,RegWrite,InstrDone,IllegalInstr}
  function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sbs,
                                     input logic [1:0] imm, input logic [1:0] op,
                                     input logic rw, input logic dn, input logic il);
    return {pcw, adr, mw, irw, rs, sa, sbs, imm, op, rw, dn, il};
  endfunction
  function automatic logic [16:0] ft(input logic r, input logic [1:0] i);
    return v(r, 1'b0, 1'b0, r, 2'b10, 2'b00, 2'b10, i, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] dc(input logic [1:0] i, input logic il);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, i, 2'b00, 1'b0, 1'b0, il);
  endfunction
  function automatic logic [16:0] ma(input logic [1:0] i);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, i, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] mr(input logic [1:0] i);
    return v(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, i, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] wb(input logic [1:0] i);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, i, 2'b00, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] mw(input logic [1:0] i, input logic r);
    return v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, i, 2'b00, 1'b0, r, 1'b0);
  endfunction
  function automatic logic [16:0] ex(input logic [1:0] i);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, i, 2'b10, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] aw(input logic [1:0] i);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, i, 2'b00, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] bq(input logic z);
    return v(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0);
  endfunction
  task automatic step(input logic [6:0] op, input logic z, input logic r, input logic rn,
                      input logic [16:0] e, input string nm);
    @(posedge clk);
    #1;
    bus.Opcode   = op;
    bus.ZeroFlag = z;
    bus.MemReady = r;
    rst_n        = rn;
    sb.push_back('{e, nm});
  endtask
  logic [16:0] got;
  assign got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ImmSrc, bus.ALUOp, bus.RegWrite, bus.InstrDone, bus.IllegalInstr};
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (got !== e.vec) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.name, got, e.vec);
      end
      n_checks++;
      if (bus.RegWrite && bus.MemWrite) begin
        n_fail++;
        $display("FAIL %s_exclusive: RegWrite=%b MemWrite=%b expected not both 1", e.name, bus.RegWrite, bus.MemWrite);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end
  initial begin
    bus.Opcode = LW;
    bus.ZeroFlag = 1'b0;
    bus.MemReady = 1'b1;
    step(LW, 1'b0, 1'b1, 1'b0, ft(1'b0, 2'b00), "reset0");
    step(LW, 1'b0, 1'b1, 1'b0, ft(1'b0, 2'b00), "reset1");
    step(LW, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b00), "lw_fetch");
    step(LW, 1'b0, 1'b1, 1'b1, dc(2'b00, 1'b0), "lw_decode");
    step(LW, 1'b0, 1'b1, 1'b1, ma(2'b00), "lw_memadr");
    step(LW, 1'b0, 1'b1, 1'b1, mr(2'b00), "lw_memread");
    step(LW, 1'b0, 1'b1, 1'b1, wb(2'b00), "lw_memwb");
    step(SW, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b01), "sw_fetch");
    step(SW, 1'b0, 1'b1, 1'b1, dc(2'b01, 1'b0), "sw_decode");
    step(SW, 1'b0, 1'b1, 1'b1, ma(2'b01), "sw_memadr");
    step(SW, 1'b0, 1'b0, 1'b1, mw(2'b01, 1'b0), "sw_memwrite_stall1");
    step(SW, 1'b0, 1'b0, 1'b1, mw(2'b01, 1'b0), "sw_memwrite_stall2");
    step(SW, 1'b0, 1'b1, 1'b1, mw(2'b01, 1'b1), "sw_memwrite_done");
    step(BQ, 1'b0, 1'b0, 1'b1, ft(1'b0, 2'b10), "beq1_fetch_stall");
    step(BQ, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b10), "beq1_fetch");
    step(BQ, 1'b0, 1'b1, 1'b1, dc(2'b10, 1'b0), "beq1_decode");
    step(BQ, 1'b1, 1'b1, 1'b1, bq(1'b1), "beq1_taken");
    step(BQ, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b10), "beq0_fetch");
    step(BQ, 1'b0, 1'b1, 1'b1, dc(2'b10, 1'b0), "beq0_decode");
    step(BQ, 1'b0, 1'b1, 1'b1, bq(1'b0), "beq0_not_taken");
    step(BAD, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b00), "ill_fetch");
    step(BAD, 1'b0, 1'b1, 1'b1, dc(2'b00, 1'b1), "ill_decode");
    step(LW, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b00), "lw2_fetch");
    step(LW, 1'b0, 1'b1, 1'b1, dc(2'b00, 1'b0), "lw2_decode");
    step(LW, 1'b0, 1'b1, 1'b1, ma(2'b00), "lw2_memadr");
    step(RT, 1'b0, 1'b0, 1'b1, mr(2'b00), "lw2_memread_opchange");
    step(LW, 1'b0, 1'b0, 1'b1, mr(2'b00), "lw2_memread_stall");
    step(LW, 1'b0, 1'b0, 1'b0, ft(1'b0, 2'b00), "reset_in_stall");
    step(RT, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b00), "rt_fetch");
    step(RT, 1'b0, 1'b1, 1'b1, dc(2'b00, 1'b0), "rt_decode");
    step(RT, 1'b0, 1'b1, 1'b1, ex(2'b00), "rt_execute");
    step(RT, 1'b0, 1'b1, 1'b1, aw(2'b00), "rt_aluwb");
    step(LW, 1'b0, 1'b1, 1'b1, ft(1'b1, 2'b00), "final_fetch");
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings are fixed constants in the shared package.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 Opcode  input  7  instruction opcode, taken from the instruction register.
REQ-005 ZeroFlag  input  1  ALU zero result.
REQ-006 MemReady  input  1  memory completes the current read or write this cycle.
REQ-007 PCWrite  output  1  PC register load enable.
REQ-008 AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
REQ-009 MemWrite  output  1  memory write strobe.
REQ-010 IRWrite  output  1  instruction register and OldPC load enable.
REQ-011 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-012 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-013 ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-014 ImmSrc  output  2  immediate format: 01 = sw, 10 = beq, 00 = otherwise.
REQ-015 ALUOp  output  2  ALU operation class: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-016 RegWrite  output  1  register file write enable.
REQ-017 InstrDone  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-018 IllegalInstr  output  1  one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-019 The block SHALL be a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, ALUWB, BEQ.
REQ-020 FETCH drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10 and IRWrite=PCWrite=MemReady.
REQ-021 FETCH holds while MemReady=0 and moves to DECODE when MemReady=1.
REQ-022 DECODE drives ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target) and takes one cycle.
REQ-023 DECODE next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 1100011 -> BEQ; any other opcode -> FETCH with IllegalInstr=1.
REQ-024 MEMADR drives ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD for lw and MEMWRITE for sw.
REQ-025 MEMREAD drives AdrSrc=1, ResultSrc=00; holds until MemReady=1, then moves to MEMWB.
REQ-026 MEMWB drives ResultSrc=01, RegWrite=1, InstrDone=1; next state is FETCH.
REQ-027 MEMWRITE drives AdrSrc=1, ResultSrc=00, MemWrite=1; holds until MemReady=1, then moves to FETCH with InstrDone=1.
REQ-028 EXECUTER drives ALUSrcA=10, ALUSrcB=00, ALUOp=10; next state is ALUWB.
REQ-029 ALUWB drives ResultSrc=00, RegWrite=1, InstrDone=1; next state is FETCH.
REQ-030 BEQ drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=ZeroFlag, InstrDone=1; next state is FETCH.
REQ-031 ImmSrc SHALL decode combinationally from Opcode in every state.
REQ-032 Any output not listed for a state is 0.
REQ-033 Latency from FETCH entry to InstrDone, with MemReady=1 throughout: lw 5 cycles, sw 4, R-type 4, beq 3. Each MemReady=0 cycle adds one cycle.
REQ-034 MemWrite SHALL remain asserted with a stable AdrSrc for every stall cycle of MEMWRITE.
REQ-035 At most one of RegWrite and MemWrite is high in any cycle.
REQ-036 Opcode changes outside DECODE and MEMADR SHALL have no effect on state.

Reset
REQ-037 With rst_n=0 at a rising edge, the state SHALL become FETCH regardless of current state, including mid-stall.
REQ-038 While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, InstrDone and IllegalInstr SHALL be 0; the mux selects take their FETCH values.
REQ-039 The first FETCH after reset release behaves per REQ-020 and REQ-021.

Structure
REQ-040 A shared package SHALL hold the state enum, the opcode constants (LW, SW, RTYPE, BEQ) and the ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings.
REQ-041 One sub-module, ctrl_imm_decode, SHALL provide the Opcode-to-ImmSrc decode.
REQ-042 The FSM SHALL use a registered state plus combinational next-state and output logic; there are no other registers.

Verification
REQ-043 lw (0000011), MemReady=1: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only.
REQ-044 sw (0100011), MemReady low for 2 MEMWRITE cycles: MemWrite=1 for 3 cycles, ImmSrc=01 throughout, InstrDone in cycle 6.
REQ-045 beq (1100011): ZeroFlag=1 gives PCWrite=1 in cycle 3; ZeroFlag=0 gives PCWrite=0 in cycle 3; ALUOp=01 in both cases.
REQ-046 Opcode 1111111: IllegalInstr=1 in cycle 2, then FETCH; RegWrite and MemWrite stay 0 throughout.
REQ-047 rst_n=0 during a MEMREAD stall: FETCH on the next edge and all strobes 0; after release, R-type (0110011) completes in 4 cycles with ALUOp=10 in EXECUTER.
